// File: rtl/rv32_types.sv
// Shared RV32 core types: memory request bundle plus the memory arbiter's
// FSM state and port identifiers.
package rv32_types;

  typedef struct packed {
    logic        do_request;
    logic        write;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  byte_en;
  } memory_request_t;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_DONE} arb_state_t;
  typedef enum logic {ARB_PORT_INSTR, ARB_PORT_DATA} arb_port_t;

  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/rv32_mem_arbiter_if.sv
// Single-port memory bus: valid/ready request channel plus response-valid channel.
interface rv32_mem_arbiter_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );
endinterface

// File: rtl/rv32_mem_arbiter.sv
// Serializes the core's fetch and data ports onto one single-port memory,
// one transaction in flight, with a one-refusal fairness guarantee.
module rv32_mem_arbiter
  import rv32_types::*;
#(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  memory_request_t        instr_request,
  output logic                   instr_request_done,
  output logic [31:0]            instr,
  input  memory_request_t        data_request,
  output logic                   data_request_done,
  output logic [31:0]            data,
  rv32_mem_arbiter_if.master     mem
);

  arb_state_t  state;
  arb_port_t   port_q, last_grant_q, win;
  logic        fair_q, both;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;

  logic unused_ok;
  assign unused_ok = ^{instr_request.write, instr_request.data, instr_request.byte_en,
                       instr_request.addr[1:0], data_request.addr[1:0]};

  assign both = instr_request.do_request & data_request.do_request;

  // fair_q means the port not served last lost a contested decision, so it wins now
  always_comb begin
    win = ARB_PORT_INSTR;
    if (data_request.do_request && !instr_request.do_request)
      win = ARB_PORT_DATA;
    else if (both) begin
      if (fair_q)
        win = (last_grant_q == ARB_PORT_DATA) ? ARB_PORT_INSTR : ARB_PORT_DATA;
      else
        win = DATA_FIRST ? ARB_PORT_DATA : ARB_PORT_INSTR;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= ARB_IDLE;
      port_q       <= ARB_PORT_INSTR;
      last_grant_q <= ARB_PORT_INSTR;
      fair_q       <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      instr        <= '0;
      data         <= '0;
    end else begin
      case (state)
        ARB_IDLE: if (instr_request.do_request || data_request.do_request) begin
          port_q       <= win;
          last_grant_q <= win;
          fair_q       <= both;
          if (win == ARB_PORT_DATA) begin
            we_q    <= data_request.write;
            addr_q  <= word_addr(data_request.addr);
            wdata_q <= data_request.data;
            be_q    <= data_request.write ? data_request.byte_en : 4'hF;
          end else begin
            we_q    <= 1'b0;
            addr_q  <= word_addr(instr_request.addr);
            wdata_q <= '0;
            be_q    <= 4'hF;
          end
          state <= ARB_ISSUE;
        end
        ARB_ISSUE: if (mem.mem_req_ready) state <= ARB_WAIT;
        ARB_WAIT: if (mem.mem_rsp_valid) begin
          if (!we_q) begin
            if (port_q == ARB_PORT_DATA) data <= mem.mem_rdata;
            else                         instr <= mem.mem_rdata;
          end
          state <= ARB_DONE;
        end
        // request inputs deliberately ignored here so a held request is not double-served
        ARB_DONE: state <= ARB_IDLE;
        default:  state <= ARB_IDLE;
      endcase
    end
  end

  assign mem.mem_req_valid = (state == ARB_ISSUE);
  assign mem.mem_we        = we_q;
  assign mem.mem_addr      = addr_q;
  assign mem.mem_wdata     = wdata_q;
  assign mem.mem_be        = be_q;

  assign instr_request_done = (state == ARB_DONE) && (port_q == ARB_PORT_INSTR);
  assign data_request_done  = (state == ARB_DONE) && (port_q == ARB_PORT_DATA);

endmodule

// File: doc/rv32_mem_arbiter.md
# rv32_mem_arbiter

Shared-memory arbiter directly downstream of the RV32 core's two memory ports. It serializes the instruction-fetch port and the data port onto one single-port memory with a valid/ready request channel and a response-valid channel. It returns per-port `request_done` pulses and held read data in the form the fetch and memory stages consume. Only one memory transaction is outstanding at any time.

## Interface
- DATA_FIRST, 1, tie-break when both ports request in the same IDLE cycle: 1 = data wins, 0 = instruction wins. Overridden by the fairness rule below.
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- instr_request  in  memory_request_t  core fetch request; fields used: do_request, addr
- instr_request_done  out  1  one-cycle completion pulse to the fetch stage
- instr  out  32  fetched word; updated only on instruction completion, otherwise held
- data_request  in  memory_request_t  core data request; fields used: do_request, write, addr, data, byte_en[3:0]
- data_request_done  out  1  one-cycle completion pulse to the memory stage
- data  out  32  load word; updated only on data-read completion, otherwise held (unchanged by writes)
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts the request when valid&ready
- mem_we  out  1  write request
- mem_addr  out  32  word address = latched addr with bits [1:0] forced to 0
- mem_wdata  out  32  write data
- mem_be  out  4  byte enables; all-ones on reads
- mem_rsp_valid  in  1  response: read data valid, or write acknowledged
- mem_rdata  in  32  read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Samples both do_request bits and selects a port.
  - Latches the port id, write, addr, data and byte_en of the winner.
  - Moves to ISSUE. With no request, stays in IDLE.
  - The grant register records which port was last served.
- Arbitration:
  - Single requester: that port wins.
  - Both requesting: the port not served last wins if it was also refused in the previous IDLE decision (fairness bit).
  - Otherwise the DATA_FIRST rule applies.
  - A port can be refused at most once in a row.
- ISSUE:
  - mem_req_valid=1, with mem_we, mem_addr, mem_wdata and mem_be driven from the latched fields.
  - On mem_req_ready, moves to WAIT.
  - Outputs stay stable while ready is low.
- WAIT:
  - On mem_rsp_valid, captures mem_rdata into instr or data, according to the latched port. A write captures nothing.
  - Moves to DONE.
  - A mem_rsp_valid seen outside WAIT is ignored.
- DONE:
  - The latched port's done output is 1 for exactly this cycle.
  - Next state is IDLE.
  - Core request inputs are not sampled in DONE, so a request the core still holds during its done cycle cannot be served twice.
- Core ports drop or change do_request after seeing done. A request still asserted in the IDLE that follows DONE is treated as a new transaction.
- Changes to core request inputs after latching have no effect on the transaction in flight.

## Timing
- Reset values:
  - state=IDLE
  - mem_req_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0
  - both done outputs =0, instr=0, data=0
  - fairness and last-grant bits =0
- Reset asserted in any state returns to IDLE on the next edge. The in-flight transaction is abandoned and no done is issued.
- All outputs are registered or decoded from state/latched registers only. No combinational path runs from any input to any output.
- Minimum latency, with request seen at cycle 0 in IDLE, ready=1 immediately and rsp_valid the cycle after acceptance:
  - mem_req_valid at cycle 1
  - WAIT at cycle 2, response at cycle 2
  - done=1 at cycle 3
  - 4-cycle minimum turnaround per transaction: IDLE, ISSUE, WAIT, DONE.
- Each cycle ready stays low adds one cycle. Each cycle in WAIT without a response adds one cycle.
- Read data appears on instr/data in the same cycle as its done pulse, and holds until that port's next read completion.

## Structure
- The rv32_types package gains:
  - arb_state_t enum {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_DONE}
  - arb_port_t enum {ARB_PORT_INSTR, ARB_PORT_DATA}
- memory_request_t remains the package's existing type.
- Single module; no sub-module is warranted. The arbitration decision is one combinational block, and the FSM plus latches is one always_ff.

## Test plan
- Single instr read, addr 0x100, memory ready=1, rsp with rdata 0xDEADBEEF one cycle later:
  - mem_req_valid at cycle 1 with mem_addr=0x100, mem_we=0, mem_be=0xF.
  - instr_request_done=1 only at cycle 3, with instr=0xDEADBEEF held afterward.
- Data write, addr 0x203, data 0x12345678, byte_en 0x3:
  - mem_addr=0x200, mem_we=1, mem_be=0x3.
  - data_request_done pulses once.
  - data output keeps its previous value.
- Simultaneous requests, DATA_FIRST=1, both held until done:
  - Grant order data, instr, data, instr.
  - Requests stay held; each port is served within 2 transactions.
- Back-pressure: mem_req_ready low for 3 cycles, then rsp delayed 2 cycles:
  - mem_addr/wdata stable throughout.
  - done arrives at cycle 3+3+2=8.
- Core holds a request through its done cycle:
  - Exactly one memory transaction per done.
  - The held request is re-issued only from the following IDLE.
- resetn=0 during WAIT, followed by a stray mem_rsp_valid:
  - All outputs return to reset values.
  - No done pulse.
  - The stray response is ignored.
